// File: rtl/dsa_pkg.sv
// -----------------------------------------------------------------------------
// dsa_pkg
// Shared definitions for the digit-serial adder:
//   - state_t     : controller states (IDLE, RUN, DONE)
//   - DEF_WIDTH   : default operand/sum width
//   - DEF_DIGIT   : default number of bits added per clock
// Optional feature macro used by the design files: DSA_SUBTRACT_EN
// -----------------------------------------------------------------------------
package dsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/rca_digit.sv
// -----------------------------------------------------------------------------
// rca_digit
// Combinational DIGIT-bit ripple-carry slice, reused once per clock by the
// digit-serial adder.
// Ports:
//   x, y  in  DIGIT  digit operands
//   ci    in  1      carry into bit 0
//   s     out DIGIT  digit sum
//   co    out 1      carry out of bit DIGIT-1
//   cm    out 1      carry into bit DIGIT-1 (used for signed overflow)
// -----------------------------------------------------------------------------
module rca_digit
  import dsa_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);

  // c[i] is the carry into bit i; c[DIGIT] is the slice carry-out.
  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[DIGIT];
  assign cm = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
// Multi-cycle adder computing {cout,sum} = a + b + cin, DIGIT bits per clock,
// least-significant digit first, using one shared rca_digit slice.
// Operands are taken on an in_valid/in_ready handshake in IDLE, the result is
// offered on out_valid/out_ready in DONE and held until accepted.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      operands present
//   in_ready   out 1      block can accept operands (IDLE only)
//   a, b       in  WIDTH  operands
//   cin        in  1      carry-in
//   sub        in  1      subtract mode        (only with DSA_SUBTRACT_EN)
//   out_valid  out 1      result present
//   out_ready  in  1      consumer accepts result
//   sum        out WIDTH  result
//   cout       out 1      carry out of bit WIDTH-1 (1 = no borrow when sub)
//   ovf        out 1      signed overflow      (only with DSA_SUBTRACT_EN)
// Optional feature macro: DSA_SUBTRACT_EN (adds sub/ovf, enables a - b).
// -----------------------------------------------------------------------------
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DSA_SUBTRACT_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;
  logic             accept;
  logic             last_digit;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;

`ifdef DSA_SUBTRACT_EN
  logic             slice_cm;
  logic             ovf_q;
`else
  logic             cm_unused;
`endif

  assign accept     = in_valid && in_ready;
  assign last_digit = (cnt == LAST);

  // Current digit of each captured operand feeds the shared slice.
  assign dig_a = op_a[int'(cnt)*DIGIT +: DIGIT];
  assign dig_b = op_b[int'(cnt)*DIGIT +: DIGIT];

  rca_digit #(
    .DIGIT(DIGIT)
  ) u_slice (
    .x (dig_a),
    .y (dig_b),
    .ci(carry),
    .s (slice_s),
    .co(slice_co),
`ifdef DSA_SUBTRACT_EN
    .cm(slice_cm)
`else
    .cm(cm_unused)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // in_ready is a pure state decode so it never depends on in_valid.
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Datapath: operand capture, per-digit accumulation and registered outputs.
  // The sum register is cleared on capture so undigested bits read as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      carry       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef DSA_SUBTRACT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= a;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef DSA_SUBTRACT_EN
            // a - b is a + ~b + 1; the forced carry replaces cin.
            op_b   <= sub ? ~b : b;
            carry  <= sub | cin;
            ovf_q  <= 1'b0;
`else
            op_b   <= b;
            carry  <= cin;
`endif
          end
        end
        RUN: begin
          sum_q[int'(cnt)*DIGIT +: DIGIT] <= slice_s;
          carry <= slice_co;
          cnt   <= cnt + 1'b1;
          if (last_digit) begin
            cout_q      <= slice_co;
            out_valid_q <= 1'b1;
`ifdef DSA_SUBTRACT_EN
            ovf_q       <= slice_cm ^ slice_co;
`endif
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef DSA_SUBTRACT_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
// Scoreboard bench for digit_serial_adder (WIDTH=16). Stimulus pushes the
// expected result from an arithmetic reference model; an independent monitor
// pops and compares whenever a result is handed over.
// Build with DSA_SUBTRACT_EN defined to also exercise sub/ovf.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

  localparam int WIDTH = 16;
  parameter  int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   randReady = 1'b0;

  digit_serial_adder #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef DSA_SUBTRACT_EN
    .sub      (sub),
    .ovf      (ovf),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

`ifndef DSA_SUBTRACT_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic s);
    exp_t   e;
    int     sx;
    int     sy;
    int     sres;
    longint full;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      full   = longint'(x) + longint'(y) + longint'(c);
      e.sum  = full[15:0];
      e.cout = full[16];
      sres   = sx + sy + int'(c);
    end else begin
      e.sum  = x - y;
      e.cout = (x >= y);
      sres   = sx - sy;
    end
    e.ovf = (sres > 32767) || (sres < -32768);
    return e;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_output", 32'(out_valid), 32'd0);
    end else begin
      e = sb.pop_front();
      check("sum", 32'(sum), 32'(e.sum));
      check("cout", 32'(cout), 32'(e.cout));
`ifdef DSA_SUBTRACT_EN
      check("ovf", 32'(ovf), 32'(e.ovf));
`endif
    end
  endtask

  // Monitor: a result is consumed at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) checkOutput();
  end

  // Random backpressure, changed well clear of both clock edges.
  always @(posedge clk) begin
    #2;
    if (randReady) out_ready = ($urandom % 2) == 1;
  end

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                               input logic c, input logic s);
    int waited = 0;
    @(negedge clk);
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    while (!in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(x, y, c, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int rc;
    logic [15:0] x;
    logic [15:0] y;
    logic c;
    logic s;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add with latency measurement.
    out_ready = 1'b1;
    applyStimulus(16'h0004, 16'h000C, 1'b0, 1'b0);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    waitOutValid(lat);
    check("latency", 32'(lat), 32'(NDIG));
    drain();

    // Full carry ripple.
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFB, 1'b1, 1'b0);
    drain();

    // Backpressure, with a stray operand pulse during RUN.
    out_ready = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waitOutValid(lat);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_sum", 32'(sum), 32'h3333);
      check("hold_cout", 32'(cout), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drain();

    // Reset part-way through RUN.
    rc = (NDIG > 2) ? 2 : NDIG - 1;
    applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    repeat (rc) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain();

`ifdef DSA_SUBTRACT_EN
    // Subtraction corner cases.
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();
`endif

    // Randomised back-to-back traffic with random backpressure.
    randReady = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom);
`ifdef DSA_SUBTRACT_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      applyStimulus(x, y, c, s);
      if (($urandom % 4) == 0) @(negedge clk);
    end
    randReady = 1'b0;
    #3;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
